// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the core's dmem port: one outstanding read or
// write, serviced from a word-organised RAM after LATENCY cycles.
module dmem_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] BASE_ADR = 32'h0000_1000,
    parameter int              DEPTH    = 1024,
    parameter int              LATENCY  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_v,
    input  logic            w_v,
    input  logic [XLEN-1:0] data_adr,
    input  logic [XLEN-1:0] data_i,
    input  logic [3:0]      strobe,
    output logic [XLEN-1:0] dmem_resp,
    output logic            dmem_resp_v,
    output logic            access_fault,
    output logic            busy
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic [XLEN-1:0] adr_r;
    logic [XLEN-1:0] wdata_r;
    logic [3:0]      strobe_r;
    logic            is_write_r;
    logic [XLEN-1:0] mem_r [DEPTH];

    logic            accept_s;
    logic            resp_entry_s;
    logic [XLEN-1:0] op_adr_s;
    logic [XLEN-1:0] op_data_s;
    logic [3:0]      op_strobe_s;
    logic            op_write_s;
    logic            op_in_range_s;
    logic [AW-1:0]   op_index_s;
    logic            mem_we_s;

    function automatic logic in_window(input logic [XLEN-1:0] adr);
        logic [XLEN:0] off;
        off       = {1'b0, adr} - {1'b0, BASE_ADR};
        in_window = (adr >= BASE_ADR) && (off < ((XLEN+1)'(DEPTH) << 2));
    endfunction

    function automatic logic [AW-1:0] win_index(input logic [XLEN-1:0] adr);
        logic [XLEN-1:0] off;
        off       = adr - BASE_ADR;
        win_index = off[AW+1:2];
    endfunction

    // Decode acceptance and the edge that enters RESP (where the RAM is touched).
    always_comb begin
        accept_s     = 1'b0;
        resp_entry_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s     = r_v | w_v;
                resp_entry_s = (r_v | w_v) && (LATENCY == 1);
            end
            WAIT: begin
                resp_entry_s = (cnt_r <= 4'd1);
            end
            RESP: begin
                resp_entry_s = 1'b0;
            end
            default: begin
                resp_entry_s = 1'b0;
            end
        endcase
    end

    // With LATENCY=1 the access happens on the accepting edge, so use live inputs.
    always_comb begin
        if (state_r == IDLE) begin
            op_adr_s    = data_adr;
            op_data_s   = data_i;
            op_strobe_s = strobe;
            op_write_s  = w_v;
        end else begin
            op_adr_s    = adr_r;
            op_data_s   = wdata_r;
            op_strobe_s = strobe_r;
            op_write_s  = is_write_r;
        end
        op_in_range_s = in_window(op_adr_s);
        op_index_s    = win_index(op_adr_s);
        mem_we_s      = resp_entry_s & op_write_s & op_in_range_s & rst_n;
    end

    // RAM array: not reset, byte-lane writes under strobe.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (op_strobe_s[b]) begin
                    mem_r[op_index_s][8*b +: 8] <= op_data_s[8*b +: 8];
                end
            end
        end
    end

    // Request FSM, wait counter and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            adr_r        <= '0;
            wdata_r      <= '0;
            strobe_r     <= 4'd0;
            is_write_r   <= 1'b0;
            dmem_resp    <= '0;
            dmem_resp_v  <= 1'b0;
            access_fault <= 1'b0;
            busy         <= 1'b0;
        end else begin
            dmem_resp_v  <= 1'b0;
            access_fault <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        adr_r      <= data_adr;
                        wdata_r    <= data_i;
                        strobe_r   <= strobe;
                        is_write_r <= w_v;
                        cnt_r      <= CNT_LOAD;
                        busy       <= 1'b1;
                        if (LATENCY > 1) begin
                            state_r <= WAIT;
                        end else begin
                            state_r <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r <= 4'd1) begin
                        state_r <= RESP;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    busy    <= 1'b0;
                end
            endcase
            if (resp_entry_s) begin
                dmem_resp_v  <= 1'b1;
                access_fault <= ~op_in_range_s;
                if (op_in_range_s && !op_write_s) begin
                    dmem_resp <= mem_r[op_index_s];
                end else begin
                    dmem_resp <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: LATENCY=1 and LATENCY=2 instances share one stimulus
// stream, each checked every cycle against a cycle-count model of the spec.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        r_v = 1'b0;
    logic        w_v = 1'b0;
    logic [31:0] data_adr = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic [3:0]  strobe = 4'd0;

    logic [31:0] resp_a  [2];
    logic        resp_v  [2];
    logic        fault_a [2];
    logic        busy_a  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[lat%0d]: got %h, expected %h", nm, g + 1, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = g + 1;

        dmem_ctrl #(
            .XLEN(32), .BASE_ADR(32'h0000_1000), .DEPTH(1024), .LATENCY(LAT)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .r_v(r_v), .w_v(w_v),
            .data_adr(data_adr), .data_i(data_i), .strobe(strobe),
            .dmem_resp(resp_a[g]), .dmem_resp_v(resp_v[g]),
            .access_fault(fault_a[g]), .busy(busy_a[g])
        );

        // Model: 'left' is the number of busy cycles still to come.
        int          left = 0;
        bit          m_v = 1'b0;
        bit          m_fault = 1'b0;
        bit          m_known = 1'b1;
        logic [31:0] m_resp = 32'd0;
        logic [31:0] c_adr, c_data;
        logic [3:0]  c_strb;
        bit          c_wr;
        logic [31:0] mm [1024];
        bit          kn [1024];

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                left = 0; m_v = 1'b0; m_fault = 1'b0; m_resp = 32'd0; m_known = 1'b1;
            end else begin
                m_v = 1'b0;
                m_fault = 1'b0;
                if (left == 0) begin
                    if (r_v || w_v) begin
                        c_adr = data_adr; c_data = data_i; c_strb = strobe; c_wr = w_v;
                        left = LAT;
                    end
                end else begin
                    left = left - 1;
                end
                if (left == 1) begin
                    longint a;
                    int     idx;
                    a = longint'(c_adr);
                    m_v = 1'b1;
                    if (a < 64'h1000 || a >= 64'h1000 + 4 * 1024) begin
                        m_fault = 1'b1; m_resp = 32'd0; m_known = 1'b1;
                    end else begin
                        idx = int'((a - 64'h1000) / 4);
                        if (c_wr) begin
                            for (int b = 0; b < 4; b++)
                                if (c_strb[b]) mm[idx][8*b +: 8] = c_data[8*b +: 8];
                            kn[idx] = kn[idx] | (c_strb == 4'hF);
                            m_resp = 32'd0; m_known = 1'b1;
                        end else begin
                            m_resp = mm[idx]; m_known = kn[idx];
                        end
                    end
                end
            end
        end

        always @(negedge clk) begin
            check("resp_v", g, {31'd0, resp_v[g]}, {31'd0, m_v});
            check("fault", g, {31'd0, fault_a[g]}, {31'd0, m_fault});
            check("busy", g, {31'd0, busy_a[g]}, {31'd0, left != 0});
            if (m_known) check("resp", g, resp_a[g], m_resp);
        end
    end

    // Holds a request until the LATENCY=2 instance acknowledges it.
    task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, output int n);
        @(negedge clk);
        r_v = r; w_v = w; data_adr = a; data_i = d; strobe = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_v[1] && n < 20);
        check("ack_seen", 1, {31'd0, resp_v[1]}, 32'd1);
        r_v = 1'b0; w_v = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        int doubles;
        bit prev;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 1, {31'd0, busy_a[1]}, 32'd0);
        check("rst_resp", 1, resp_a[1], 32'd0);
        #1 rst_n = 1'b1;

        do_req(1'b1, 1'b0, 32'h1000, 32'd0, 4'h0, n);
        check("rd_latency", 1, n, 32'd2);
        check("rd_fault", 1, {31'd0, fault_a[1]}, 32'd0);
        check("rd_busy_resp", 1, {31'd0, busy_a[1]}, 32'd1);
        @(negedge clk);
        check("rd_pulse_end", 1, {31'd0, resp_v[1]}, 32'd0);
        check("rd_busy_end", 1, {31'd0, busy_a[1]}, 32'd0);

        do_req(1'b0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, n);
        do_req(1'b0, 1'b1, 32'h1004, 32'hAABB_CCDD, 4'hF, n);
        do_req(1'b0, 1'b1, 32'h1004, 32'h1122_3344, 4'h3, n);
        do_req(1'b1, 1'b0, 32'h1004, 32'd0, 4'h0, n);
        check("strobe_merge", 1, resp_a[1], 32'hAABB_3344);

        do_req(1'b1, 1'b0, 32'h0FFC, 32'd0, 4'h0, n);
        check("oor_rd_fault", 1, {31'd0, fault_a[1]}, 32'd1);
        check("oor_rd_data", 1, resp_a[1], 32'd0);
        do_req(1'b0, 1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, n);
        check("oor_wr_fault", 1, {31'd0, fault_a[1]}, 32'd1);
        do_req(1'b1, 1'b0, 32'h1000, 32'd0, 4'h0, n);
        check("after_oor", 1, resp_a[1], 32'hCAFE_F00D);

        do_req(1'b1, 1'b1, 32'h1008, 32'h5A5A_5A5A, 4'hF, n);
        check("both_is_wr", 1, resp_a[1], 32'd0);
        do_req(1'b1, 1'b0, 32'h1008, 32'd0, 4'h0, n);
        check("both_readback", 1, resp_a[1], 32'h5A5A_5A5A);

        do_req(1'b0, 1'b1, 32'h1004, 32'hFFFF_FFFF, 4'h0, n);
        do_req(1'b1, 1'b0, 32'h1004, 32'd0, 4'h0, n);
        check("strobe0", 1, resp_a[1], 32'hAABB_3344);

        // Abort an accepted write with reset one cycle later.
        do_req(1'b0, 1'b1, 32'h1010, 32'h0102_0304, 4'hF, n);
        @(negedge clk);
        w_v = 1'b1; data_adr = 32'h1010; data_i = 32'hDEAD_BEEF; strobe = 4'hF;
        @(negedge clk);
        #1 rst_n = 1'b0; w_v = 1'b0;
        @(negedge clk);
        check("abort_busy", 1, {31'd0, busy_a[1]}, 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", 1, {31'd0, resp_v[1]}, 32'd0);
        end
        do_req(1'b1, 1'b0, 32'h1010, 32'd0, 4'h0, n);
        check("abort_kept", 1, resp_a[1], 32'h0102_0304);

        // Continuous read into the LATENCY=1 instance.
        @(negedge clk);
        r_v = 1'b1; data_adr = 32'h1000;
        pulses = 0; doubles = 0; prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_v[0]) pulses++;
            if (resp_v[0] && prev) doubles++;
            prev = resp_v[0];
        end
        r_v = 1'b0;
        check("lat1_pulses", 0, pulses, 32'd5);
        check("lat1_width", 0, doubles, 32'd0);
        check("lat1_data", 0, resp_a[0], 32'hCAFE_F00D);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
